// File: rtl/calc_key_if.sv
// Keypad event channel: valid/ready handshake carrying key type and payload.
interface calc_key_if #(
  parameter int DIG_W = 4
);
  logic             key_valid;
  logic             key_ready;
  logic [1:0]       key_type;
  logic [DIG_W-1:0] key_data;

  // Keypad side: presents key events and holds them until accepted.
  modport master (
    output key_valid,
    output key_type,
    output key_data,
    input  key_ready
  );

  // Controller side: accepts key events.
  modport slave (
    input  key_valid,
    input  key_type,
    input  key_data,
    output key_ready
  );
endinterface

// File: rtl/calc_controller.sv
// Calculator control FSM: sequences keypad events into one-cycle datapath
// micro-operations (load/clear pulses, ALU mux select, opcode, display select).
//
// state   | meaning
// --------+--------------------------------------------------------------
// CLR     | clear input reg, accumulator and opcode reg; reset state
// ENTER_A | waiting for first-operand digit, operator, or clear
// LD_A    | load digit into input register
// XFER_A  | copy input register into accumulator
// LD_OP   | load opcode register; second operand not yet entered
// ENTER_B | waiting for second-operand digit, operator, equals, clear
// LD_B    | load second-operand digit into input register
// EXEC_CH | execute pending op before a chained operator is loaded
// EXEC    | execute op on equals
// RESULT  | showing result; equals repeats, digit starts over
module calc_controller #(
  parameter int DIG_W = 4,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  calc_key_if.slave        key_if,
  output logic [DIG_W-1:0] digit_out_o,
  output logic [OP_W-1:0]  op_out_o,
  output logic             load_number_o,
  output logic             clear_number_o,
  output logic             inSelect_o,
  output logic             load_result_o,
  output logic             clear_result_o,
  output logic             load_code_o,
  output logic             clear_code_o,
  output logic             sel_display_o
);

  localparam logic [1:0] KEY_DIGIT = 2'b00;
  localparam logic [1:0] KEY_OP    = 2'b01;
  localparam logic [1:0] KEY_EQ    = 2'b10;
  localparam logic [1:0] KEY_CLR   = 2'b11;

  typedef enum logic [3:0] {
    S_CLR     = 4'd0,
    S_ENTER_A = 4'd1,
    S_LD_A    = 4'd2,
    S_XFER_A  = 4'd3,
    S_LD_OP   = 4'd4,
    S_ENTER_B = 4'd5,
    S_LD_B    = 4'd6,
    S_EXEC_CH = 4'd7,
    S_EXEC    = 4'd8,
    S_RESULT  = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic             b_entered_q, b_entered_d;
  logic [DIG_W-1:0] digit_q;
  logic [OP_W-1:0]  op_q;
  logic             ready;
  logic             accept;

  assign key_if.key_ready = ready;
  assign accept           = key_if.key_valid & ready;
  assign digit_out_o      = digit_q;
  assign op_out_o         = op_q;

  // State and second-operand flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLR;
      b_entered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_entered_q <= b_entered_d;
    end
  end

  // Capture key payload on acceptance; the opcode is captured immediately
  // so it is already valid when LD_OP pulses load_code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      op_q    <= '0;
    end else if (accept) begin
      if (key_if.key_type == KEY_DIGIT) digit_q <= key_if.key_data;
      if (key_if.key_type == KEY_OP)    op_q    <= key_if.key_data[OP_W-1:0];
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d        = state_q;
    b_entered_d    = b_entered_q;
    ready          = 1'b0;
    load_number_o  = 1'b0;
    clear_number_o = 1'b0;
    inSelect_o     = 1'b0;
    load_result_o  = 1'b0;
    clear_result_o = 1'b0;
    load_code_o    = 1'b0;
    clear_code_o   = 1'b0;
    sel_display_o  = 1'b0;
    case (state_q)
      S_CLR: begin
        clear_number_o = 1'b1;
        clear_result_o = 1'b1;
        clear_code_o   = 1'b1;
        b_entered_d    = 1'b0;
        state_d        = S_ENTER_A;
      end
      S_ENTER_A: begin
        ready = 1'b1;
        if (accept) begin
          case (key_if.key_type)
            KEY_DIGIT: state_d = S_LD_A;
            KEY_OP:    state_d = S_LD_OP;
            KEY_CLR:   state_d = S_CLR;
            default:   state_d = S_ENTER_A;
          endcase
        end
      end
      S_LD_A: begin
        load_number_o = 1'b1;
        state_d       = S_XFER_A;
      end
      S_XFER_A: begin
        load_result_o = 1'b1;
        state_d       = S_ENTER_A;
      end
      S_LD_OP: begin
        load_code_o   = 1'b1;
        sel_display_o = 1'b1;
        b_entered_d   = 1'b0;
        state_d       = S_ENTER_B;
      end
      S_ENTER_B: begin
        ready         = 1'b1;
        sel_display_o = ~b_entered_q;
        if (accept) begin
          case (key_if.key_type)
            KEY_DIGIT: state_d = S_LD_B;
            KEY_OP:    state_d = b_entered_q ? S_EXEC_CH : S_LD_OP;
            KEY_EQ:    state_d = b_entered_q ? S_EXEC : S_ENTER_B;
            default:   state_d = S_CLR;
          endcase
        end
      end
      S_LD_B: begin
        load_number_o = 1'b1;
        b_entered_d   = 1'b1;
        state_d       = S_ENTER_B;
      end
      S_EXEC_CH: begin
        inSelect_o    = 1'b1;
        load_result_o = 1'b1;
        sel_display_o = 1'b1;
        state_d       = S_LD_OP;
      end
      S_EXEC: begin
        inSelect_o    = 1'b1;
        load_result_o = 1'b1;
        sel_display_o = 1'b1;
        state_d       = S_RESULT;
      end
      S_RESULT: begin
        ready         = 1'b1;
        sel_display_o = 1'b1;
        if (accept) begin
          case (key_if.key_type)
            KEY_DIGIT: state_d = S_LD_A;
            KEY_OP:    state_d = S_LD_OP;
            KEY_EQ:    state_d = S_EXEC;
            default:   state_d = S_CLR;
          endcase
        end
      end
      default: state_d = S_CLR;
    endcase
  end

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
Control FSM for the 4-bit calculator. It sits directly upstream of the calculator datapath and drives every datapath control and data input: load/clear pulses, ALU mux select, opcode and display select. Keypad events arrive over a valid/ready handshake and are sequenced into one-cycle datapath micro-operations. The block supports first-operand entry, operator entry, second-operand entry, equals, chained operators, repeat-equals and clear.

Parameters:
DIG_W, 4, width of digit value and of datapath input register data
OP_W, 3, width of operation code

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  key event present; held until accepted
key_ready  output  1  FSM can accept a key this cycle
key_type  input  2  00 digit, 01 operator, 10 equals, 11 clear
key_data  input  DIG_W  digit value (type 00) or opcode in [OP_W-1:0] (type 01); otherwise ignored
digit_out  output  DIG_W  to datapath inputRegD; registered
op_out  output  OP_W  to datapath OpCode; registered
load_number  output  1  datapath input register load
clear_number  output  1  datapath input register clear
inSelect  output  1  ALU mux: 0 = input register, 1 = ALU result
load_result  output  1  accumulator load
clear_result  output  1  accumulator clear
load_code  output  1  opcode register load
clear_code  output  1  opcode register clear
sel_display  output  1  0 = show input register, 1 = show accumulator

Behaviour:
- Handshake: a key is accepted on a rising edge where key_valid && key_ready. key_ready is high only in ENTER_A, ENTER_B and RESULT; it is low in all transient states.
- On acceptance, digit_out <= key_data for digits and op_out <= key_data[OP_W-1:0] for operators. Both hold their value otherwise. Both reset to 0.
- All control outputs are Moore-decoded from the registered state. Each transient state lasts exactly 1 cycle. Any output not listed for a state is 0.
- States and transitions:
  - CLR: clear_number = clear_result = clear_code = 1; sel_display = 0. Next state is ENTER_A. This is the reset state. b_entered <= 0.
  - ENTER_A: sel_display = 0.
    - digit -> LD_A.
    - op -> LD_OP (accumulator operand is its current value, 0 after clear).
    - equals: accepted and dropped; stay in ENTER_A.
    - clear -> CLR.
  - LD_A: load_number = 1, sel_display = 0. Next state is XFER_A.
  - XFER_A: inSelect = 0, load_result = 1, sel_display = 0. Next state is ENTER_A.
  - LD_OP: load_code = 1, sel_display = 1. Next state is ENTER_B; b_entered <= 0.
  - ENTER_B: sel_display = b_entered ? 0 : 1.
    - digit -> LD_B.
    - op with b_entered = 1 -> EXEC_CH.
    - op with b_entered = 0 -> LD_OP (the operator is replaced).
    - equals with b_entered = 1 -> EXEC.
    - equals with b_entered = 0: dropped.
    - clear -> CLR.
  - LD_B: load_number = 1, sel_display = 0. Next state is ENTER_B; b_entered <= 1.
  - EXEC_CH: inSelect = 1, load_result = 1, sel_display = 1. Next state is LD_OP. The new op_out is already captured, and the ALU uses the old opcode this cycle because the opcode register has not yet loaded.
  - EXEC: inSelect = 1, load_result = 1, sel_display = 1. Next state is RESULT.
  - RESULT: sel_display = 1.
    - digit -> LD_A (a new calculation begins; the accumulator is overwritten in XFER_A).
    - op -> LD_OP (chain on the result).
    - equals -> EXEC (repeat the last op with the same second operand).
    - clear -> CLR.
- Latency: for a key accepted at edge N, its first micro-op is active during cycle N to N+1.
  - Digit in ENTER_A: the input register updates at N+1 and the accumulator at N+2. key_ready returns high at cycle N+2.
  - Operator chain from ENTER_B: accumulator at N+1, opcode register at N+2.
- Reset: asserting rst_n low at any time, including mid-sequence, forces state CLR, digit_out = 0, op_out = 0, b_entered = 0 and key_ready = 0 immediately. The datapath clears in the first cycle after release.
- Clear key: never partially applied. Clear is only accepted in a ready state, so any in-flight micro-op sequence completes first.
- Opcode values are passed through unchecked. ALU semantics belong to the datapath.
- Encoding: binary or one-hot, implementer's choice. No illegal-state lockup: any unused encoding returns to CLR.

Test Plan:
- Reset then idle, key_valid = 0:
  - Cycle 1: clear_number/clear_result/clear_code = 1.
  - Then ENTER_A with key_ready = 1, sel_display = 0, all loads 0.
- Digit 5 accepted at edge N:
  - Cycle N: load_number = 1, digit_out = 5, key_ready = 0.
  - Cycle N+1: load_result = 1, inSelect = 0.
  - Cycle N+2: key_ready = 1.
- Sequence digit 3, op 3'b010, digit 4, equals:
  - load_code pulses exactly once with op_out = 2.
  - EXEC asserts inSelect = 1 and load_result = 1 for 1 cycle.
  - Ends in RESULT with sel_display = 1.
- Chained sequence digit 2, op 1, digit 6, op 3:
  - EXEC_CH cycle has inSelect = 1 and load_result = 1.
  - The next cycle has load_code = 1 with op_out = 3.
  - Then ENTER_B with sel_display = 1.
- Edge cases:
  - Equals in ENTER_A, or in ENTER_B before any digit: no load pulse, state unchanged.
  - Equals twice in RESULT: two EXEC pulses.
  - Op, then op 5 before any digit: only the opcode is reloaded, op_out = 5, no load_result.
- rst_n pulsed low during XFER_A, and key_valid held with key_ready = 0: no acceptance until ready. After reset, CLR outputs appear and digit_out/op_out read 0.
